// File: rtl/sos_pkg.sv
// Shared widths and types for the sum-of-squares accumulator
// that feeds the Q16.16 square-root pipeline.
package sos_pkg;

    localparam int SOS_SAMPLE_W = 16;
    localparam int SOS_ACC_W    = 32;
    localparam int SOS_CNT_W    = 16;

    typedef logic [2*SOS_SAMPLE_W-1:0] sq_t;
    typedef logic [SOS_ACC_W-1:0]      acc_t;
    typedef logic [SOS_CNT_W-1:0]      cnt_t;

    localparam acc_t ACC_MAX = '1;

endpackage

// File: rtl/sos_square.sv
// One-stage registered signed squarer; valid and last travel
// alongside the unsigned product.
import sos_pkg::*;

module sos_square #(
    parameter int SAMPLE_W = SOS_SAMPLE_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       valid_in,
    input  logic                       last_in,
    output logic [2*SAMPLE_W-1:0]      sq_out,
    output logic                       valid_out,
    output logic                       last_out
);

    logic signed [2*SAMPLE_W-1:0] prod;
    logic [2*SAMPLE_W-1:0]        sq_d, sq_q;
    logic                         valid_d, valid_q;
    logic                         last_d, last_q;

    // Square of any two's complement value is non-negative and fits.
    always_comb begin
        prod    = sample_in * sample_in;
        sq_d    = unsigned'(prod);
        valid_d = valid_in;
        last_d  = valid_in & last_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sq_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sq_q    <= sq_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign sq_out    = sq_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;

endmodule

// File: rtl/sum_of_squares_acc.sv
// Framed sum-of-squares accumulator: square, saturating accumulate,
// then a registered result with a one-cycle valid pulse.
import sos_pkg::*;

module sum_of_squares_acc #(
    parameter int SAMPLE_W = SOS_SAMPLE_W,
    parameter int ACC_W    = SOS_ACC_W,
    parameter int CNT_W    = SOS_CNT_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sample_last,
    output logic [ACC_W-1:0]           sum_out,
    output logic                       sum_valid,
    output logic [CNT_W-1:0]           sum_count,
    output logic                       sum_sat,
    output logic                       busy
);

    localparam logic [ACC_W-1:0] ACC_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [2*SAMPLE_W-1:0] a_sq;
    logic                  a_valid;
    logic                  a_last;

    sos_square #(
        .SAMPLE_W (SAMPLE_W)
    ) u_square (
        .clock     (clock),
        .reset     (reset),
        .sample_in (sample_in),
        .valid_in  (sample_valid),
        .last_in   (sample_last),
        .sq_out    (a_sq),
        .valid_out (a_valid),
        .last_out  (a_last)
    );

    logic [ACC_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sat_d, sat_q;
    logic             open_d, open_q;
    logic             fin_d, fin_q;
    logic             first;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_w;

    logic [ACC_W-1:0] sum_out_d, sum_out_q;
    logic [CNT_W-1:0] sum_count_d, sum_count_q;
    logic             sum_sat_d, sum_sat_q;
    logic             sum_valid_d, sum_valid_q;
    logic             busy_d, busy_q;

    // A frame opens on the first sample after reset or after a last.
    always_comb begin
        first  = !open_q;
        base   = first ? '0 : acc_q;
        sum_w  = {1'b0, base} + (ACC_W+1)'(a_sq);
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        open_d = open_q;
        fin_d  = a_valid & a_last;
        if (a_valid) begin
            acc_d  = sum_w[ACC_W] ? ACC_ONES : sum_w[ACC_W-1:0];
            sat_d  = (!first & sat_q) | sum_w[ACC_W];
            open_d = !a_last;
            if (first)
                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_ONES)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        sum_out_d   = sum_out_q;
        sum_count_d = sum_count_q;
        sum_sat_d   = sum_sat_q;
        sum_valid_d = fin_q;
        if (fin_q) begin
            sum_out_d   = acc_q;
            sum_count_d = cnt_q;
            sum_sat_d   = sat_q;
        end
        busy_d = busy_q;
        if (sample_valid)
            busy_d = !sample_last;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            open_q      <= 1'b0;
            fin_q       <= 1'b0;
            sum_out_q   <= '0;
            sum_count_q <= '0;
            sum_sat_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            open_q      <= open_d;
            fin_q       <= fin_d;
            sum_out_q   <= sum_out_d;
            sum_count_q <= sum_count_d;
            sum_sat_q   <= sum_sat_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sum_out   = sum_out_q;
    assign sum_count = sum_count_q;
    assign sum_sat   = sum_sat_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sum_of_squares_acc.sv
// Scoreboard bench for sum_of_squares_acc: a frame model pushes
// expected results, the output pulse pops and compares them.
import sos_pkg::*;

module tb_sum_of_squares_acc;

    logic               clock;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               sample_last;
    logic [31:0]        sum_out;
    logic               sum_valid;
    logic [15:0]        sum_count;
    logic               sum_sat;
    logic               busy;

    sum_of_squares_acc dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .sum_out      (sum_out),
        .sum_valid    (sum_valid),
        .sum_count    (sum_count),
        .sum_sat      (sum_sat),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        acc_t sum;
        cnt_t cnt;
        logic sat;
        int   due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    acc_t m_acc;
    cnt_t m_cnt;
    logic m_sat;
    logic m_open;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h cyc=%0d",
                     tag, got, exp, cycle);
        end
    endtask

    task automatic observe();
        exp_t e;
        check("busy", 32'(busy), 32'(m_open));
        if (sum_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'(sum_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("latency", cycle, e.due);
                check("sum", sum_out, e.sum);
                check("count", 32'(sum_count), 32'(e.cnt));
                check("sat", 32'(sum_sat), 32'(e.sat));
            end
        end else if (q.size() != 0 && q[0].due <= cycle) begin
            check("missing_valid", 32'(sum_valid), 32'd1);
            void'(q.pop_front());
        end
    endtask

    task automatic model(input logic signed [15:0] s, input logic l);
        logic [32:0] t;
        longint      ss;
        exp_t        e;
        ss = longint'(s);
        if (!m_open) begin
            m_acc = '0;
            m_cnt = '0;
            m_sat = 1'b0;
        end
        t = {1'b0, m_acc} + 33'(ss * ss);
        if (t[32]) begin
            m_acc = 32'hFFFF_FFFF;
            m_sat = 1'b1;
        end else begin
            m_acc = t[31:0];
        end
        if (m_cnt != 16'hFFFF)
            m_cnt = m_cnt + 16'd1;
        if (l) begin
            e.sum = m_acc;
            e.cnt = m_cnt;
            e.sat = m_sat;
            e.due = cycle + 2;
            q.push_back(e);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic cyc(input logic v, input logic signed [15:0] s,
                       input logic l);
        sample_valid = v;
        sample_in    = s;
        sample_last  = l;
        @(posedge clock);
        cycle++;
        if (v)
            model(s, l);
        #1;
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 16'sd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            cycle++;
        end
        #1;
        reset  = 1'b0;
        m_open = 1'b0;
        q.delete();
        check("rst_sum", sum_out, 32'd0);
        check("rst_count", 32'(sum_count), 32'd0);
        check("rst_sat", 32'(sum_sat), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        sample_last  = 1'b0;
        m_acc        = '0;
        m_cnt        = '0;
        m_sat        = 1'b0;
        m_open       = 1'b0;
        do_reset(2);

        cyc(1'b1, 16'sd3, 1'b0);
        cyc(1'b1, 16'sd4, 1'b1);
        idle(4);

        cyc(1'b1, -16'sd32768, 1'b1);
        idle(4);

        for (int i = 0; i < 5; i++)
            cyc(1'b1, -16'sd32768, i == 4);
        cyc(1'b1, 16'sd1, 1'b1);
        idle(4);

        cyc(1'b1, 16'sd1, 1'b0);
        cyc(1'b1, 16'sd2, 1'b1);
        cyc(1'b1, 16'sd3, 1'b1);
        idle(4);

        cyc(1'b1, 16'sd5, 1'b0);
        cyc(1'b0, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 1'b0);
        cyc(1'b1, 16'sd12, 1'b1);
        idle(4);

        cyc(1'b1, 16'sd10, 1'b0);
        cyc(1'b1, 16'sd10, 1'b0);
        do_reset(1);
        cyc(1'b1, 16'sd2, 1'b1);
        idle(4);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                gap = $urandom_range(0, 3);
                if (gap == 0)
                    cyc(1'b0, 16'sd0, 1'($urandom_range(0, 1)));
                cyc(1'b1, 16'($urandom), k == n - 1);
            end
        end
        idle(6);
        if (q.size() != 0)
            check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
